// File: rtl/seq_left_shift_32bit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_left_shift_32bit_pkg
// Purpose  : Shared widths, FSM and op encodings for the sequential shifter
// Revision : 1.0
// ============================================================================
package seq_left_shift_32bit_pkg;

  localparam int c_width   = 32;
  localparam int c_shamt_w = 5;
  localparam int c_stage_w = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  typedef enum logic {
    OP_SLL = 1'b0,
    OP_ROL = 1'b1
  } op_t;

endpackage
`default_nettype wire

// File: rtl/seq_left_shift_32bit_stage.sv
`default_nettype none
// ============================================================================
// Module   : left_shift_stage
// Purpose  : One binary-weighted shift/rotate step of 2^stage positions
// Revision : 1.0
// ============================================================================
module left_shift_stage
  import seq_left_shift_32bit_pkg::*;
#(
  parameter int WIDTH   = c_width,
  parameter int SHAMT_W = c_shamt_w
) (
  input  logic [WIDTH-1:0]     data,
  input  logic [c_stage_w-1:0] stage,
  input  logic                 en,
  input  op_t                  mode,
  output logic [WIDTH-1:0]     result
);

  logic [SHAMT_W-1:0] w_n;
  logic [2*WIDTH-1:0] w_wide;

  // Shifting {data, fill} left leaves the rotated/zero-filled word in the top half
  assign w_n    = SHAMT_W'(1) << stage;
  assign w_wide = {data, (mode == OP_ROL) ? data : {WIDTH{1'b0}}} << w_n;
  assign result = en ? w_wide[2*WIDTH-1:WIDTH] : data;

endmodule
`default_nettype wire

// File: rtl/seq_left_shift_32bit.sv
`default_nettype none
// ============================================================================
// Module   : seq_left_shift_32bit
// Purpose  : Five-cycle SLL / rotate-left unit with valid/ready on both sides
// Revision : 1.0
// ============================================================================
module seq_left_shift_32bit
  import seq_left_shift_32bit_pkg::*;
#(
  parameter int WIDTH   = c_width,
  parameter int SHAMT_W = c_shamt_w
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] b,
  input  logic               op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WIDTH-1:0]       r_acc;
  logic [SHAMT_W-1:0]     r_amt;
  op_t                    r_mode;
  logic [c_stage_w-1:0]   r_stage;
  logic [WIDTH-1:0]       r_out;
  logic [WIDTH-1:0]       w_stage_out;

  left_shift_stage #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_stage (
    .data   (r_acc),
    .stage  (r_stage),
    .en     (r_amt[r_stage]),
    .mode   (r_mode),
    .result (w_stage_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)                  w_state_nxt = SHIFT;
      SHIFT:   if (r_stage == c_stage_w'(4))  w_state_nxt = DONE;
      DONE:    if (out_ready)                 w_state_nxt = IDLE;
      default:                                w_state_nxt = IDLE;
    endcase
  end

  // The result copy is loaded only on the final stage so out stays frozen during SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_amt   <= '0;
      r_mode  <= OP_SLL;
      r_stage <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc   <= a;
            r_amt   <= b;
            r_mode  <= op_t'(op);
            r_stage <= '0;
          end
        end
        SHIFT: begin
          r_acc   <= w_stage_out;
          r_stage <= r_stage + c_stage_w'(1);
          if (r_stage == c_stage_w'(4)) begin
            r_out <= w_stage_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out       = r_out;

endmodule
`default_nettype wire

// File: tb/tb_seq_left_shift_32bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_left_shift_32bit
// Purpose  : Self-checking bench: vector table, scoreboard, corner sequences
// Revision : 1.0
// ============================================================================
module tb_seq_left_shift_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [4:0]  b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [31:0] va;
    logic [4:0]  vb;
    logic        vop;
    logic [31:0] vexp;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  seq_left_shift_32bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] ma, input logic [4:0] mb, input logic mop);
    logic [5:0] rs;
    rs = 6'd32 - {1'b0, mb};
    if (mop) return (ma << mb) | (ma >> rs);
    return ma << mb;
  endfunction

  // One transaction: fixed 5-cycle latency, frozen out during SHIFT, optional backpressure/disturbance
  task automatic run_op(input logic [31:0] ta, input logic [4:0] tbv, input logic top,
                        input logic [31:0] texp, input int hold, input bit disturb);
    int n;
    logic [31:0] prev;
    logic [31:0] exp;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before_req", {31'b0, in_ready}, 32'd1);
    prev = out;
    a = ta; b = tbv; op = top; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(texp);
    #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (disturb) begin
        a = $urandom; b = 5'($urandom_range(0, 31)); op = ~op; in_valid = ~in_valid;
      end
      @(posedge clk); #1;
      if (k < 5) begin
        chk("out_valid_during_shift", {31'b0, out_valid}, 32'd0);
        chk("in_ready_during_shift", {31'b0, in_ready}, 32'd0);
        chk("out_frozen_during_shift", out, prev);
      end else begin
        chk("out_valid_at_latency5", {31'b0, out_valid}, 32'd1);
      end
    end
    in_valid = 1'b0;
    prev = out;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a = $urandom; b = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_out_stable", out, prev);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      exp = sb.pop_front();
      chk("result", out, exp);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_xfer", {31'b0, in_ready}, 32'd1);
    chk("out_valid_after_xfer", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [4:0]  rb;
    logic        rop;

    vecs[0]  = '{32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000};
    vecs[1]  = '{32'hFFFF_FFFF, 5'd4,  1'b0, 32'hFFFF_FFF0};
    vecs[2]  = '{32'hFFFF_FFFF, 5'd0,  1'b0, 32'hFFFF_FFFF};
    vecs[3]  = '{32'h8000_0001, 5'd1,  1'b1, 32'h0000_0003};
    vecs[4]  = '{32'h1234_5678, 5'd16, 1'b1, 32'h5678_1234};
    vecs[5]  = '{32'h0000_00FF, 5'd8,  1'b0, 32'h0000_FF00};
    vecs[6]  = '{32'hF000_000F, 5'd4,  1'b1, 32'h0000_00FF};
    vecs[7]  = '{32'h8000_0000, 5'd31, 1'b1, 32'h4000_0000};
    vecs[8]  = '{32'hDEAD_BEEF, 5'd31, 1'b0, 32'h8000_0000};
    vecs[9]  = '{32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678};
    vecs[10] = '{32'hA5A5_A5A5, 5'd5,  1'b0, 32'hB4B4_B4A0};
    vecs[11] = '{32'h0000_0001, 5'd21, 1'b1, 32'h0020_0000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out", out, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vop, vecs[i].vexp, 0, 1'b0);
    end

    // Backpressure: result held for 10 cycles while new requests are offered
    run_op(32'h1234_5678, 5'd16, 1'b1, 32'h5678_1234, 10, 1'b0);

    // Operand churn and in_valid toggling during SHIFT must not leak in
    run_op(32'h8000_0001, 5'd1, 1'b1, 32'h0000_0003, 0, 1'b1);
    run_op(32'hFFFF_FFFF, 5'd4, 1'b0, 32'hFFFF_FFF0, 2, 1'b1);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = 5'($urandom_range(0, 31)); rop = 1'($urandom_range(0, 1));
      run_op(ra, rb, rop, model(ra, rb, rop), i % 3, i[0]);
    end

    // Asynchronous reset in the middle of SHIFT (stage 2)
    a = 32'h0000_00FF; b = 5'd8; op = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(32'h0000_FF00);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midreset_out", out, 32'd0);
    void'(sb.pop_back());
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("no_stale_out_valid", {31'b0, out_valid}, 32'd0);
    end
    run_op(32'h0000_00FF, 5'd8, 1'b0, 32'h0000_FF00, 0, 1'b0);

    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
